// File: rtl/halut_pkg.sv
// Shared SCM geometry and loader state definitions for the HALUT datapath.
package halut_pkg;

    localparam int unsigned HalutC         = 32;
    localparam int unsigned HalutK         = 16;
    localparam int unsigned HalutDataWidth = 16;
    localparam int unsigned ScmDepth       = HalutC * HalutK;
    localparam int unsigned ScmAddrWidth   = $clog2(ScmDepth);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2
    } loader_state_e;

endpackage

// File: rtl/scm_addr_counter.sv
// Burst address generator: loads base/count, advances with wrap at the SCM depth,
// and flags when the remaining count is empty or about to empty.
module scm_addr_counter
    import halut_pkg::*;
#(
    parameter int unsigned Depth     = ScmDepth,
    parameter int unsigned AddrWidth = ScmAddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth:0]   count_i,
    input  logic                 inc_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 zero_o,
    output logic                 last_o
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth:0]   remaining_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (load_i) begin
            addr_q      <= base_i;
            remaining_q <= count_i;
        end else if (inc_i && !zero_o) begin
            // Explicit wrap so non-power-of-two depths still fold back to 0
            addr_q      <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign addr_o = addr_q;
    assign zero_o = (remaining_q == '0);
    assign last_o = (remaining_q == {{AddrWidth{1'b0}}, 1'b1});

endmodule

// File: rtl/scm_loader.sv
// Streams LUT words from a valid/ready source into the SCM write port as one
// contiguous (wrapping) address burst, with registered write outputs.
module scm_loader
    import halut_pkg::*;
#(
    parameter int unsigned C              = HalutC,
    parameter int unsigned K              = HalutK,
    parameter int unsigned DataTypeWidth  = HalutDataWidth,
    parameter int unsigned TotalAddrWidth = $clog2(C * K)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [TotalAddrWidth-1:0] base_addr_i,
    input  logic [TotalAddrWidth:0]   num_words_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DataTypeWidth-1:0]  in_data_i,
    output logic [TotalAddrWidth-1:0] waddr_o,
    output logic [DataTypeWidth-1:0]  wdata_o,
    output logic                      we_o,
    output logic                      busy_o,
    output logic                      done_o
);

    loader_state_e state_q, state_d;

    logic [TotalAddrWidth-1:0] cur_addr;
    logic                      cnt_zero;
    logic                      cnt_last;
    logic                      start_ok;
    logic                      xfer;
    logic                      burst_end;

    logic [TotalAddrWidth-1:0] waddr_q;
    logic [DataTypeWidth-1:0]  wdata_q;
    logic                      we_q;
    logic                      done_q;

    assign start_ok   = (state_q == StIdle) && start_i;
    assign in_ready_o = (state_q == StLoad) && !cnt_zero;
    assign xfer       = in_valid_i && in_ready_o;
    assign burst_end  = xfer && cnt_last;
    assign busy_o     = (state_q != StIdle);

    scm_addr_counter #(
        .Depth     (C * K),
        .AddrWidth (TotalAddrWidth)
    ) u_addr_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (start_ok),
        .base_i  (base_addr_i),
        .count_i (num_words_i),
        .inc_i   (xfer),
        .addr_o  (cur_addr),
        .zero_o  (cnt_zero),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok && (num_words_i != '0)) state_d = StLoad;
            StLoad:  if (burst_end) state_d = StFlush;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= xfer;
            // Zero-length requests complete immediately without entering LOAD
            done_q  <= (start_ok && (num_words_i == '0)) || burst_end;
            if (xfer) begin
                waddr_q <= cur_addr;
                wdata_q <= in_data_i;
            end
        end
    end

    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign we_o    = we_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_scm_loader.sv
// Randomized self-checking bench for scm_loader against a cycle-level burst model
// and a shadow SCM memory filled from the DUT write port.
module tb_scm_loader;

    localparam int D = 512;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [8:0]  base_addr_i = '0;
    logic [9:0]  num_words_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] in_data_i = '0;
    logic [8:0]  waddr_o;
    logic [15:0] wdata_o;
    logic        we_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    scm_loader dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_words_i (num_words_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .we_o        (we_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 accepting words, 2 final write cycle
    int          m_phase = 0;
    int          m_left = 0;
    int          m_addr = 0;
    logic        m_we = 1'b0;
    int          m_waddr = 0;
    int          m_wdata = 0;
    logic        m_done = 1'b0;
    logic [15:0] acc_q[$];

    logic [15:0] scm[D];
    int          cyc, done_cyc, we_cnt;
    int          waddr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc    = (m_phase == 1) && in_valid_i;
        m_done = 1'b0;
        m_we   = acc;
        if (acc) begin
            m_waddr = m_addr;
            m_wdata = int'(in_data_i);
            acc_q.push_back(in_data_i);
        end
        case (m_phase)
            0: if (start_i) begin
                if (num_words_i == 0) m_done = 1'b1;
                else begin
                    m_phase = 1;
                    m_addr  = int'(base_addr_i);
                    m_left  = int'(num_words_i);
                    acc_q.delete();
                end
            end
            1: if (acc) begin
                m_addr = (m_addr + 1) % D;
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_done  = 1'b1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic step(input bit st, input int base, input int num, input bit v,
                        input logic [15:0] d);
        start_i     = st;
        base_addr_i = base[8:0];
        num_words_i = num[9:0];
        in_valid_i  = v;
        in_data_i   = d;
        chk("in_ready", in_ready_o, m_phase == 1);
        @(posedge clk_i);
        model_edge();
        #1;
        if (we_o === 1'b1) begin
            scm[waddr_o] = wdata_o;
            we_cnt++;
            waddr_log.push_back(int'(waddr_o));
        end
        if (done_o === 1'b1 && done_cyc < 0) done_cyc = cyc + 1;
        cyc++;
        chk("we", we_o, m_we);
        chk("waddr", waddr_o, m_waddr);
        chk("wdata", wdata_o, m_wdata);
        chk("done", done_o, m_done);
        chk("busy", busy_o, m_phase != 0);
        start_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_we", we_o, 0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", in_ready_o, 0);
        m_phase = 0; m_left = 0; m_addr = 0;
        m_we = 1'b0; m_waddr = 0; m_wdata = 0; m_done = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic begin_burst();
        cyc = 0;
        done_cyc = -1;
        we_cnt = 0;
        waddr_log.delete();
    endtask

    task automatic check_mem(input int base);
        for (int k = 0; k < acc_q.size(); k++)
            chk("mem", scm[(base + k) % D], acc_q[k]);
    endtask

    task automatic run_burst(input int base, input int num, input int vpct,
                             input int inj_at, input int inj_base);
        begin_burst();
        step(1'b1, base, num, 1'b0, 16'($urandom));
        for (int i = 1; i < 10 * num + 40 && m_phase != 0; i++)
            step(i == inj_at, inj_base, 5, $urandom_range(99) < vpct, 16'($urandom));
        chk("burst_idle", busy_o, 0);
        if (num > 0) begin
            chk("accepted", acc_q.size(), num);
            check_mem(base);
        end
    endtask

    initial begin
        int wexp[4];
        bit pat[5];
        int b;

        apply_reset();

        // Full-depth load with continuous valid
        run_burst(0, 512, 100, -1, 0);
        chk("full_done_cycle", done_cyc, 513);
        chk("full_we_count", we_cnt, 512);
        chk("full_first_addr", waddr_log[0], 0);
        chk("full_last_addr", waddr_log[511], 511);

        // Address wrap at the top of the SCM
        wexp = '{510, 511, 0, 1};
        run_burst(510, 4, 100, -1, 0);
        chk("wrap_we_count", we_cnt, 4);
        for (int i = 0; i < 4 && i < waddr_log.size(); i++)
            chk("wrap_addr", waddr_log[i], wexp[i]);
        chk("wrap_done_cycle", done_cyc, 5);

        // Stall pattern preserves data order
        b = $urandom_range(D - 1);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        begin_burst();
        step(1'b1, b, 3, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 0, pat[i], 16'h1000 + 16'(i));
        step(1'b0, 0, 0, 1'b1, 16'h2000);
        chk("stall_we_count", we_cnt, 3);
        chk("stall_done_cycle", done_cyc, 6);
        chk("stall_w0", scm[b % D], 16'h1000);
        chk("stall_w1", scm[(b + 1) % D], 16'h1003);
        chk("stall_w2", scm[(b + 2) % D], 16'h1004);

        // Zero-length request
        run_burst(77, 0, 100, -1, 0);
        step(1'b0, 0, 0, 1'b1, 16'h55);
        chk("zero_we_count", we_cnt, 0);
        chk("zero_done_cycle", done_cyc, 1);

        // Reset in the middle of a burst
        begin_burst();
        step(1'b1, 37, 10, 1'b0, 16'h0);
        for (int i = 0; i < 20 && we_cnt < 5; i++) step(1'b0, 0, 0, 1'b1, 16'($urandom));
        chk("abort_we_seen", we_cnt, 5);
        apply_reset();
        begin_burst();
        step(1'b0, 0, 0, 1'b1, 16'h1234);
        step(1'b0, 0, 0, 1'b1, 16'h4321);
        chk("abort_no_write", we_cnt, 0);
        run_burst(200, 3, 100, -1, 0);
        chk("post_reset_we", we_cnt, 3);

        // Start during LOAD with a different base is ignored
        run_burst(300, 8, 100, 3, 10);
        chk("inject_addr0", waddr_log[0], 300);
        chk("inject_addr7", waddr_log[7], 307);

        // Randomized bursts with random stalls and stray starts
        for (int r = 0; r < 8; r++)
            run_burst($urandom_range(D - 1), $urandom_range(24, 1), $urandom_range(100, 40),
                      $urandom_range(12, 1), $urandom_range(D - 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scm_loader.md
SCM_LOADER -- requirements
Module: scm_loader

Interface
REQ-001 Parameter C, default 32: number of codebooks stored in the downstream SCM.
REQ-002 Parameter K, default 16: number of prototypes per codebook.
REQ-003 Parameter DataTypeWidth, default 16: LUT word width.
REQ-004 Parameter TotalAddrWidth, default $clog2(C*K): SCM address width.
REQ-005 One clock; reset is asynchronous and active-low; ports clk_i, rst_ni.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 start_i  input  1  one-cycle request to begin a load burst.
REQ-009 base_addr_i  input  TotalAddrWidth  first SCM address of the burst, sampled with start_i.
REQ-010 num_words_i  input  TotalAddrWidth+1  burst length, 0..C*K, sampled with start_i.
REQ-011 in_valid_i  input  1  upstream LUT word valid.
REQ-012 in_ready_o  output  1  loader accepts a word this cycle.
REQ-013 in_data_i  input  DataTypeWidth  upstream LUT word.
REQ-014 waddr_o  output  TotalAddrWidth  SCM write address.
REQ-015 wdata_o  output  DataTypeWidth  SCM write data.
REQ-016 we_o  output  1  SCM write enable.
REQ-017 busy_o  output  1  burst in progress; SCM reads are not valid while high.
REQ-018 done_o  output  1  one-cycle pulse when the last word is written.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FLUSH.
REQ-020 IDLE->LOAD on start_i with num_words_i>0; start_i with num_words_i==0 SHALL stay in IDLE and pulse done_o the next cycle.
REQ-021 start_i SHALL be ignored outside IDLE.
REQ-022 in_ready_o SHALL be 1 only in LOAD; a word transfers when in_valid_i && in_ready_o.
REQ-023 Each transfer SHALL register waddr_o=current address, wdata_o=in_data_i, we_o=1 in the following cycle (latency 1); otherwise we_o=0 and waddr_o/wdata_o hold.
REQ-024 Current address SHALL start at base_addr_i and increment by 1 per transfer, wrapping from C*K-1 to 0.
REQ-025 Remaining count SHALL decrement per transfer; the transfer that brings it to 0 SHALL move LOAD->FLUSH.
REQ-026 FLUSH SHALL last exactly one cycle (the last we_o), assert done_o in that cycle, then return to IDLE.
REQ-027 busy_o SHALL be 1 in LOAD and FLUSH, 0 in IDLE.
REQ-028 in_valid_i low in LOAD SHALL stall without timeout; words arriving in IDLE/FLUSH SHALL be ignored (not accepted).
REQ-029 At most one write per cycle; back-to-back transfers SHALL yield we_o high on consecutive cycles.

Reset
REQ-030 Reset SHALL force IDLE, in_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0, done_o=0, counters=0.
REQ-031 Reset mid-burst SHALL abort immediately; no further writes; remaining words are not stored.

Structure
REQ-032 FSM state enum and the C*K depth constant SHALL live in a shared package (halut_pkg) alongside the SCM geometry parameters.
REQ-033 The address/count logic SHALL be a sub-module scm_addr_counter (load, increment, wrap, zero flag); FSM stays in scm_loader.
REQ-034 Outputs waddr_o/wdata_o/we_o SHALL be registered so they drive the SCM write port directly.

Verification
REQ-035 Full load: start_i, base 0, num 512, in_valid_i constant 1 -> 512 consecutive we_o, addresses 0..511, done_o on cycle 513 after start.
REQ-036 Wrap: base 510, num 4 -> waddr_o 510,511,0,1; busy_o falls after done_o.
REQ-037 Stall: num 3, in_valid_i pattern 1,0,0,1,1 -> we_o only after valid cycles, data order preserved.
REQ-038 Zero length: num 0 -> no we_o, busy_o stays 0, done_o single pulse.
REQ-039 Reset after 5 of 10 words -> we_o 0 from reset assertion, state IDLE, new start_i accepted after release.
REQ-040 start_i during LOAD with different base -> ignored, original address sequence continues.
